// File: rtl/proj_switch_pkg.sv
// Shared defaults and FSM encoding for the project switch controller and the
// input/output muxes that consume the design select.
package proj_switch_pkg;

  localparam int unsigned DEF_SEL_BITS      = 3;
  localparam int unsigned DEF_NUM_DESIGNS   = 8;
  localparam int unsigned DEF_RST_CYCLES    = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  localparam int unsigned DEF_CNT_W         = 8;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_RUN     = 2'd0;
  localparam logic [ST_W-1:0] ST_QUIESCE = 2'd1;
  localparam logic [ST_W-1:0] ST_GATE    = 2'd2;
  localparam logic [ST_W-1:0] ST_WAKE    = 2'd3;

  // Outputs carried by each state: design reset (active-low) and clock enable.
  function automatic logic state_rst_n(input logic [ST_W-1:0] st);
    return (st == ST_RUN);
  endfunction

  function automatic logic state_clk_en(input logic [ST_W-1:0] st);
    return (st != ST_GATE);
  endfunction

endpackage

// File: rtl/proj_switch_ctrl_seq_timer.sv
// Loadable down-counter shared by every timed state of the switch sequencer.
// done_o is high while the count is zero; the count saturates there.
module seq_timer #(
  parameter int unsigned     CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/proj_switch_ctrl.sv
// Sequences a safe change of the active user design: reset it, gate its clock,
// move the select while gated, then restart the new design under reset.
module proj_switch_ctrl
  import proj_switch_pkg::*;
#(
  parameter int unsigned SEL_BITS      = DEF_SEL_BITS,
  parameter int unsigned NUM_DESIGNS   = DEF_NUM_DESIGNS,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid,
  input  logic [SEL_BITS-1:0] req_sel,
  output logic                req_ready,
  output logic [SEL_BITS-1:0] sel_o,
  output logic                proj_rst_n_o,
  output logic                clk_en_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned SEL_W1 = SEL_BITS + 1;

  localparam logic [SEL_BITS:0] NUM_D     = SEL_W1'(NUM_DESIGNS);
  localparam logic [CNT_W-1:0]  RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  logic [ST_W-1:0]     state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [SEL_BITS-1:0] pend_sel_q, pend_sel_d;
  logic                err_q, err_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_value;
  logic                tmr_done;
  logic                req_legal;

  assign req_legal = ({1'b0, req_sel} < NUM_D);

  seq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (SETTLE_LD)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  // Next-state, pending select and error tracking; timer reloads on every state entry.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pend_sel_d = pend_sel_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    case (state_q)
      ST_RUN: begin
        if (req_valid) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            pend_sel_d = req_sel;
            state_d    = ST_QUIESCE;
            tmr_load   = 1'b1;
            tmr_value  = RST_LD;
          end
        end
      end

      ST_QUIESCE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          // A request for the running design is a soft re-reset: no gating needed.
          if (pend_sel_q != sel_q) begin
            state_d   = ST_GATE;
            sel_d     = pend_sel_q;
            tmr_value = SETTLE_LD;
          end else begin
            state_d   = ST_WAKE;
            tmr_value = RST_LD;
          end
        end
      end

      ST_GATE: begin
        if (tmr_done) begin
          state_d   = ST_WAKE;
          tmr_load  = 1'b1;
          tmr_value = RST_LD;
        end
      end

      ST_WAKE: begin
        if (tmr_done) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d   = ST_GATE;
        tmr_load  = 1'b1;
        tmr_value = SETTLE_LD;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_GATE;
      sel_q      <= '0;
      pend_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pend_sel_q <= pend_sel_d;
      err_q      <= err_d;
    end
  end

  assign sel_o        = sel_q;
  assign err_o        = err_q;
  assign req_ready    = (state_q == ST_RUN);
  assign busy_o       = (state_q != ST_RUN);
  assign proj_rst_n_o = state_rst_n(state_q);
  assign clk_en_o     = state_clk_en(state_q);

endmodule

// File: tb/tb_proj_switch_ctrl.sv
// Bench for proj_switch_ctrl: directed scenarios plus random requests, compared
// every cycle against a schedule-of-outputs reference model.
module tb_proj_switch_ctrl;

  localparam int unsigned SEL_BITS      = 3;
  localparam int unsigned NUM_DESIGNS   = 6;
  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned CNT_W         = 8;

  logic                wb_clk_i;
  logic                wb_rst_i;
  logic                req_valid;
  logic [SEL_BITS-1:0] req_sel;
  logic                req_ready;
  logic [SEL_BITS-1:0] sel_o;
  logic                proj_rst_n_o;
  logic                clk_en_o;
  logic                busy_o;
  logic                err_o;

  int n_chk = 0;
  int n_bad = 0;

  proj_switch_ctrl #(
    .SEL_BITS      (SEL_BITS),
    .NUM_DESIGNS   (NUM_DESIGNS),
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .sel_o        (sel_o),
    .proj_rst_n_o (proj_rst_n_o),
    .clk_en_o     (clk_en_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of the (rst_n, clk_en, sel) triples the next cycles must show.
  typedef struct packed {
    logic                rst_n;
    logic                clk_en;
    logic [SEL_BITS-1:0] sel;
  } exp_t;

  exp_t                q[$];
  exp_t                m_cur;
  logic [SEL_BITS-1:0] m_sel;
  logic                m_err;
  bit                  m_valid = 1'b0;

  function automatic exp_t mk(input logic r, input logic c, input logic [SEL_BITS-1:0] s);
    exp_t e;
    e.rst_n  = r;
    e.clk_en = c;
    e.sel    = s;
    return e;
  endfunction

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      q.delete();
      m_sel = '0;
      m_err = 1'b0;
      for (int i = 0; i < int'(SETTLE_CYCLES); i++) q.push_back(mk(1'b0, 1'b0, '0));
      for (int i = 0; i < int'(RST_CYCLES); i++)    q.push_back(mk(1'b0, 1'b1, '0));
    end else if (m_valid && m_cur.rst_n && req_valid) begin
      if (int'(req_sel) >= int'(NUM_DESIGNS)) begin
        m_err = 1'b1;
      end else begin
        m_err = 1'b0;
        for (int i = 0; i < int'(RST_CYCLES); i++) q.push_back(mk(1'b0, 1'b1, m_sel));
        if (req_sel != m_sel)
          for (int i = 0; i < int'(SETTLE_CYCLES); i++) q.push_back(mk(1'b0, 1'b0, req_sel));
        for (int i = 0; i < int'(RST_CYCLES); i++) q.push_back(mk(1'b0, 1'b1, req_sel));
        m_sel = req_sel;
      end
    end
    if (q.size() > 0) m_cur = q.pop_front();
    else              m_cur = mk(1'b1, 1'b1, m_sel);
    if (wb_rst_i) m_valid = 1'b1;
  end

  always @(negedge wb_clk_i) begin
    if (m_valid) begin
      check_eq("sel_o",        32'(sel_o),        32'(m_cur.sel));
      check_eq("proj_rst_n_o", 32'(proj_rst_n_o), 32'(m_cur.rst_n));
      check_eq("clk_en_o",     32'(clk_en_o),     32'(m_cur.clk_en));
      check_eq("req_ready",    32'(req_ready),    32'(m_cur.rst_n));
      check_eq("busy_o",       32'(busy_o),       32'(!m_cur.rst_n));
      check_eq("err_o",        32'(err_o),        32'(m_err));
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200; i++) begin
      if (req_ready) return;
      tick();
    end
    check_eq("wait_run_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Issue one single-cycle request from RUN and return edges until RUN again.
  task automatic request(input logic [SEL_BITS-1:0] s, output int lat);
    wait_run();
    req_valid = 1'b1;
    req_sel   = s;
    tick();
    req_valid = 1'b0;
    count_to_ready(lat);
  endtask

  int lat;

  initial begin
    wb_rst_i  = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    repeat (3) @(posedge wb_clk_i);
    #2;

    // Reset release with no request.
    check_eq("rst_sel", 32'(sel_o), 32'd0);
    wb_rst_i = 1'b0;
    count_to_ready(lat);
    check_eq("rst_to_run", 32'(lat), 32'd6);

    // Switch 0 -> 5.
    request(3'd5, lat);
    check_eq("switch_lat", 32'(lat), 32'(2 * RST_CYCLES + SETTLE_CYCLES));
    check_eq("switch_sel", 32'(sel_o), 32'd5);

    // Soft re-reset on 5.
    request(3'd5, lat);
    check_eq("rereset_lat", 32'(lat), 32'(2 * RST_CYCLES));
    check_eq("rereset_sel", 32'(sel_o), 32'd5);

    // Illegal select, then a legal one clears the error.
    wait_run();
    req_valid = 1'b1;
    req_sel   = 3'd7;
    tick();
    req_valid = 1'b0;
    check_eq("illegal_err",   32'(err_o),     32'd1);
    check_eq("illegal_ready", 32'(req_ready), 32'd1);
    check_eq("illegal_sel",   32'(sel_o),     32'd5);
    request(3'd1, lat);
    check_eq("legal_clears_err", 32'(err_o), 32'd0);

    // Reset during the first GATE cycle of a switch to 3.
    wait_run();
    req_valid = 1'b1;
    req_sel   = 3'd3;
    tick();
    req_valid = 1'b0;
    repeat (RST_CYCLES) tick();
    check_eq("gate_clk_en", 32'(clk_en_o), 32'd0);
    check_eq("gate_sel",    32'(sel_o),    32'd3);
    wb_rst_i = 1'b1;
    tick();
    check_eq("abort_sel",    32'(sel_o),        32'd0);
    check_eq("abort_clk_en", 32'(clk_en_o),     32'd0);
    check_eq("abort_rst_n",  32'(proj_rst_n_o), 32'd0);
    wb_rst_i = 1'b0;
    count_to_ready(lat);
    check_eq("abort_restart", 32'(lat), 32'd6);

    // Request held through busy with a changing select: only the RUN-time value counts.
    wait_run();
    req_valid = 1'b1;
    req_sel   = 3'd2;
    tick();
    repeat (3) tick();
    req_sel = 3'd4;
    count_to_ready(lat);
    check_eq("hold_first_sel", 32'(sel_o), 32'd2);
    tick();
    req_valid = 1'b0;
    check_eq("hold_accepted", 32'(busy_o), 32'd1);
    count_to_ready(lat);
    check_eq("hold_final_sel", 32'(sel_o), 32'd4);

    // Random requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_sel   = SEL_BITS'($urandom_range(0, 7));
      wb_rst_i  = ($urandom_range(0, 299) == 0);
      tick();
    end
    wb_rst_i  = 1'b0;
    req_valid = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
